// File: rtl/pc_pkg.sv
// Shared next-PC select encoding and default parameter values for the PC sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        RET    = 3'd1,
        CALL   = 3'd2,
        JUMP   = 3'd3,
        BRANCH = 3'd4,
        INC    = 3'd5
    } nxt_sel_t;

    localparam int PC_W_DEF      = 9;
    localparam int OFF_W_DEF     = 9;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int RESET_PC_DEF  = 0;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular LIFO, push overwrites the oldest entry when full.
// Latency: push/pop take effect on the next rising edge; top_dat is combinational from state.
// Backpressure: none; the caller never pushes and pops in the same cycle.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_dat,
    output logic [W-1:0] top_dat,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] top_idx;
    logic [CW-1:0] cnt;

    // ptr names the next free slot; when full that slot holds the oldest entry.
    assign top_idx = ptr - AW'(1);
    assign top_dat = mem[top_idx];
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + AW'(1);
            if (!full) begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr <= ptr - AW'(1);
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with priority next-PC select (stall>ret>call>jump>branch>inc) and return stack.
// Latency: pc and stack status update one edge after the request.
// Backpressure: stall holds pc, stack and sticky flags for that cycle.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int OFF_W     = OFF_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int RESET_PC  = RESET_PC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             take_branch,
    input  logic [OFF_W-1:0] offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    nxt_sel_t        sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] ras_top;

    assign pc_inc = pc + PC_W'(1);

    generate
        if (OFF_W >= PC_W) begin : g_off_trunc
            assign off_ext = offset[PC_W-1:0];
        end else begin : g_off_sext
            assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
        end
    endgenerate

    // A ret on an empty stack degrades to a plain increment.
    always_comb begin
        sel = INC;
        if (stall) begin
            sel = HOLD;
        end else if (ret) begin
            sel = ras_empty ? INC : RET;
        end else if (call) begin
            sel = CALL;
        end else if (jump) begin
            sel = JUMP;
        end else if (take_branch) begin
            sel = BRANCH;
        end
    end

    always_comb begin
        pc_nxt = pc_inc;
        case (sel)
            HOLD:    pc_nxt = pc;
            RET:     pc_nxt = ras_top;
            CALL:    pc_nxt = target;
            JUMP:    pc_nxt = target;
            BRANCH:  pc_nxt = pc + off_ext;
            INC:     pc_nxt = pc_inc;
            default: pc_nxt = pc_inc;
        endcase
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (sel == CALL),
        .pop      (sel == RET),
        .push_dat (pc_inc),
        .top_dat  (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= PC_W'(RESET_PC);
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (sel == CALL && ras_full) begin
                ras_overflow <= 1'b1;
            end
            if (!stall && ret && ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

    localparam int PC_W  = 9;
    localparam int OFF_W = 9;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << PC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             take_branch = 1'b0;
    logic [OFF_W-1:0] offset = '0;
    logic             jump = 1'b0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [PC_W-1:0]  target = '0;
    logic [PC_W-1:0]  pc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;

    int checks = 0;
    int errors = 0;

    int m_pc = 0;
    int m_stk[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W      (PC_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .take_branch   (take_branch),
        .offset        (offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .pc            (pc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input bit st, input bit br, input logic [OFF_W-1:0] off,
                              input bit j, input bit c, input bit r, input int tgt);
        if (st) begin
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc = (m_pc + 1) & MASK;
                m_unf = 1;
            end
        end else if (c) begin
            m_stk.push_back((m_pc + 1) & MASK);
            if (m_stk.size() > DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1;
            end
            m_pc = tgt;
        end else if (j) begin
            m_pc = tgt;
        end else if (br) begin
            m_pc = (m_pc + int'($signed(off))) & MASK;
        end else begin
            m_pc = (m_pc + 1) & MASK;
        end
    endtask

    // Apply one cycle of requests, advance the model, and leave time at posedge+1.
    task automatic cycle(input bit st, input bit br, input logic [OFF_W-1:0] off,
                         input bit j, input bit c, input bit r, input int tgt);
        stall = st; take_branch = br; offset = off;
        jump = j; call = c; ret = r; target = PC_W'(tgt);
        @(posedge clk);
        model_step(st, br, off, j, c, r, tgt);
        #1;
        stall = 0; take_branch = 0; offset = '0;
        jump = 0; call = 0; ret = 0; target = '0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (pc !== PC_W'(0) || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
            ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h e=%b f=%b o=%b u=%b, want pc=0 e=1 f=0 o=0 u=0",
                     pc, ras_empty, ras_full, ras_overflow, ras_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, '0, 0, 0, 0, 0);
            checks++;
            if (pc !== PC_W'(i) || ras_empty !== 1'b1) begin
                errors++;
                $display("FAIL idle_inc%0d: pc=%h e=%b, want pc=%h e=1", i, pc, ras_empty, i);
            end
        end
    endtask

    task automatic test_branch();
        cycle(0, 0, '0, 1, 0, 0, 10);
        cycle(0, 1, 9'h1FC, 0, 0, 0, 0);
        checks++;
        if (pc !== 9'd6) begin
            errors++;
            $display("FAIL branch_neg: pc=%h want 006", pc);
        end
        cycle(0, 0, '0, 1, 0, 0, 'h1FF);
        cycle(0, 0, '0, 0, 0, 0, 0);
        checks++;
        if (pc !== 9'd0) begin
            errors++;
            $display("FAIL inc_wrap: pc=%h want 000", pc);
        end
        cycle(0, 1, 9'h0FF, 1, 0, 0, 'h33);
        checks++;
        if (pc !== PC_W'(m_pc) || pc !== 9'h033) begin
            errors++;
            $display("FAIL jump_over_branch: pc=%h want 033", pc);
        end
    endtask

    task automatic test_call_ret();
        int exp_seq[4] = '{'h40, 'h80, 'h42, 6};
        int got_seq[4];
        cycle(0, 0, '0, 1, 0, 0, 5);
        cycle(0, 0, '0, 0, 1, 0, 'h40);
        got_seq[0] = int'(pc);
        cycle(0, 0, '0, 0, 0, 0, 0);
        cycle(0, 0, '0, 0, 1, 0, 'h80);
        got_seq[1] = int'(pc);
        cycle(0, 0, '0, 0, 0, 1, 0);
        got_seq[2] = int'(pc);
        cycle(0, 0, '0, 0, 0, 1, 0);
        got_seq[3] = int'(pc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_seq[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL call_ret_seq%0d: pc=%h want %h", i, got_seq[i], exp_seq[i]);
            end
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL call_ret_empty: e=%b u=%b want e=1 u=0", ras_empty, ras_underflow);
        end
    endtask

    task automatic test_overflow();
        int pushed[5];
        for (int i = 0; i < 5; i++) begin
            pushed[i] = (m_pc + 1) & MASK;
            cycle(0, 0, '0, 0, 1, 0, 'h100 + i * 'h10);
        end
        checks++;
        if (ras_full !== 1'b1 || ras_overflow !== 1'b1 || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL overflow_flags: f=%b o=%b e=%b want f=1 o=1 e=0",
                     ras_full, ras_overflow, ras_empty);
        end
        for (int i = 4; i >= 1; i--) begin
            cycle(0, 0, '0, 0, 0, 1, 0);
            checks++;
            if (pc !== PC_W'(pushed[i]) || pc !== PC_W'(m_pc)) begin
                errors++;
                $display("FAIL overflow_pop%0d: pc=%h want %h", i, pc, pushed[i]);
            end
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drained: e=%b f=%b want e=1 f=0", ras_empty, ras_full);
        end
    endtask

    task automatic test_underflow();
        logic [PC_W-1:0] held;
        cycle(0, 0, '0, 1, 0, 0, 7);
        cycle(0, 0, '0, 0, 0, 1, 0);
        checks++;
        if (pc !== 9'd8 || ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: pc=%h u=%b e=%b want pc=008 u=1 e=1", pc, ras_underflow, ras_empty);
        end
        cycle(0, 0, '0, 0, 1, 0, 'h20);
        cycle(0, 0, '0, 0, 1, 0, 'h30);
        checks++;
        if (ras_underflow !== 1'b1 || pc !== 9'h030) begin
            errors++;
            $display("FAIL underflow_sticky: u=%b pc=%h want u=1 pc=030", ras_underflow, pc);
        end
        held = pc;
        cycle(1, 1, 9'h005, 1, 1, 1, 'h1AA);
        checks++;
        if (pc !== held || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: pc=%h e=%b f=%b want pc=%h e=0 f=0", pc, ras_empty, ras_full, held);
        end
        cycle(0, 0, '0, 0, 0, 1, 0);
        checks++;
        if (pc !== 9'h021) begin
            errors++;
            $display("FAIL stall_stack_intact: pc=%h want 021", pc);
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, '0, 0, 1, 0, 'h150);
        checks++;
        if (ras_empty !== 1'b0 || ras_overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: e=%b o=%b want e=0 o=1", ras_empty, ras_overflow);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (pc !== 9'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
            ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h e=%b f=%b o=%b u=%b want pc=0 e=1 f=0 o=0 u=0",
                     pc, ras_empty, ras_full, ras_overflow, ras_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, '0, 0, 0, 1, 0);
        checks++;
        if (pc !== 9'd1 || ras_underflow !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ret: pc=%h u=%b want pc=001 u=1", pc, ras_underflow);
        end
    endtask

    task automatic test_random();
        bit st, br, j, c, r;
        logic [OFF_W-1:0] off;
        int tgt;
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 2) == 0);
            off = OFF_W'($urandom);
            tgt = int'($urandom_range(0, MASK));
            cycle(st, br, off, j, c, r, tgt);
            checks++;
            if (pc !== PC_W'(m_pc) || ras_empty !== (m_stk.size() == 0) ||
                ras_full !== (m_stk.size() == DEPTH) ||
                ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
                errors++;
                $display("FAIL random%0d: pc=%h e=%b f=%b o=%b u=%b want pc=%h e=%b f=%b o=%b u=%b",
                         i, pc, ras_empty, ras_full, ras_overflow, ras_underflow,
                         m_pc, m_stk.size() == 0, m_stk.size() == DEPTH, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
